// File: rtl/full_adder_v2.sv
// full_adder_v2: 1-bit full adder with a combinational output pair, a
// registered result pair qualified by in_valid, and an optional saturating
// count of accepted operations that produced a carry.
//
// Optional feature macro: FULL_ADDER_V2_STATS_EN
//   defined   -> carry_cnt counts accepted operations with Cout=1,
//                saturating at 2^CNT_W-1 and cleared by rst.
//   undefined -> counter logic is omitted and carry_cnt is tied to 0.
//
// Reset is synchronous and active-high. It clears only the registered path;
// Sum/Cout keep following A/B/Cin while rst is asserted.

module full_adder_v2 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   output logic             Sum,
   output logic             Cout,
   input  logic             A,
   input  logic             B,
   input  logic             Cin,
   input  logic             in_valid,
   output logic             sum_q,
   output logic             cout_q,
   output logic             out_valid,
   output logic [CNT_W-1:0] carry_cnt
);

   logic sum_d;
   logic cout_d;
   logic out_valid_d;
   logic out_valid_q;

   // Zero-latency adder outputs, independent of clk, rst and in_valid.
   always_comb begin
      Sum  = A ^ B ^ Cin;
      Cout = (A & B) | (A & Cin) | (B & Cin);
   end

   // Next-state for the result pair: load on in_valid, otherwise hold.
   // Selecting the hold path on in_valid=0 keeps unknown A/B/Cin out of state.
   always_comb begin
      // NOTE: every variable assigned in always_comb gets a default on entry;
      // a path that leaves one unassigned would infer a latch.
      sum_d       = sum_q;
      cout_d      = cout_q;
      out_valid_d = in_valid;
      if (in_valid) begin
         sum_d  = Sum;
         cout_d = Cout;
      end
   end

   // Result registers; rst wins over a valid operation on the same edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         sum_q       <= 1'b0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;

`ifdef FULL_ADDER_V2_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] carry_cnt_d;
   logic [CNT_W-1:0] carry_cnt_q;

   // Saturating increment on every accepted operation that carries out.
   always_comb begin
      carry_cnt_d = carry_cnt_q;
      if (in_valid && Cout && (carry_cnt_q != CNT_MAX)) begin
         carry_cnt_d = carry_cnt_q + CNT_ONE;
      end
   end

   // Carry-event counter register, cleared by rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         carry_cnt_q <= '0;
      end else begin
         carry_cnt_q <= carry_cnt_d;
      end
   end

   assign carry_cnt = carry_cnt_q;
`else
   assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_full_adder_v2.sv
// tb_full_adder_v2: self-checking bench for full_adder_v2. The reference
// model is arithmetic: {Cout,Sum} = A+B+Cin, registered outputs track the
// last accepted result, and the carry count is an integer clamped at
// 2^CNT_W-1 (or 0 when FULL_ADDER_V2_STATS_EN is undefined).

module tb_full_adder_v2;

   localparam int CNT_W = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             Sum;
   logic             Cout;
   logic             A;
   logic             B;
   logic             Cin;
   logic             in_valid;
   logic             sum_q;
   logic             cout_q;
   logic             out_valid;
   logic [CNT_W-1:0] carry_cnt;

   int n_vec  = 0;
   int n_miss = 0;

   // reference model state
   logic m_sum_q;
   logic m_cout_q;
   logic m_out_valid;
   int   m_cnt;

   full_adder_v2 #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .Sum       (Sum),
      .Cout      (Cout),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .in_valid  (in_valid),
      .sum_q     (sum_q),
      .cout_q    (cout_q),
      .out_valid (out_valid),
      .carry_cnt (carry_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int expected_cnt(input int c);
`ifdef FULL_ADDER_V2_STATS_EN
      return c;
`else
      return 0 * c;
`endif
   endfunction

   // Combinational check against plain addition.
   task automatic check_comb(input string tag);
      int s;
      s = int'(A) + int'(B) + int'(Cin);
      check({tag, ".Sum"},  16'(Sum),  16'(s % 2));
      check({tag, ".Cout"}, 16'(Cout), 16'(s / 2));
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".sum_q"},     16'(sum_q),     16'(m_sum_q));
      check({tag, ".cout_q"},    16'(cout_q),    16'(m_cout_q));
      check({tag, ".out_valid"}, 16'(out_valid), 16'(m_out_valid));
      check({tag, ".carry_cnt"}, 16'(carry_cnt), 16'(expected_cnt(m_cnt)));
   endtask

   // One cycle: drive at negedge, check comb, advance model at posedge, check regs.
   task automatic step(input logic a, input logic b, input logic c,
                       input logic v, input logic r, input string tag);
      int s;
      @(negedge clk);
      A = a; B = b; Cin = c; in_valid = v; rst = r;
      #1;
      check_comb(tag);
      @(posedge clk);
      s = int'(a) + int'(b) + int'(c);
      if (r) begin
         m_sum_q = 1'b0; m_cout_q = 1'b0; m_out_valid = 1'b0; m_cnt = 0;
      end else begin
         m_out_valid = v;
         if (v) begin
            m_sum_q  = 1'((s % 2));
            m_cout_q = 1'((s / 2));
            if (s >= 2 && m_cnt < CNT_MAX) m_cnt++;
         end
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      m_sum_q = 1'b0; m_cout_q = 1'b0; m_out_valid = 1'b0; m_cnt = 0;
      A = 1'b0; B = 1'b0; Cin = 1'b0; in_valid = 1'b0; rst = 1'b1;

      // reset state
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "reset0");
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "reset1");

      // exhaustive truth table, 20 time units apart, rst held low and idle
      rst = 1'b0;
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         {A, B, Cin} = 3'(i);
         #1;
         check_comb($sformatf("tt%0d", i));
         #19;
      end
      m_out_valid = 1'b0;

      // registered path and hold
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "load110");
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "hold001");
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "hold010");

      // reset priority over a valid 1,1,1 operation
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "rstprio");

      // first edge after reset release accepts
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "release");

      // randomized stream with occasional reset pulses
      for (int i = 0; i < 200; i++) begin
         logic [2:0] abc;
         abc = 3'($urandom_range(0, 7));
         step(abc[2], abc[1], abc[0], 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 19) == 0), "rand");
      end

      // counter saturation: 300 back-to-back valid 1,1,1 cycles after reset
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "cntrst");
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "sat");
      end
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "satidle");
      check("sat_final", 16'(carry_cnt), 16'(expected_cnt(CNT_MAX)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/full_adder_v2.md
FULL_ADDER_V2 -- requirements
Module: full_adder_v2

Interface
REQ-001 Parameter CNT_W, default 8: width of the carry-event statistics counter; legal range 2..16.
REQ-002 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1: reset; synchronous and active-high.
REQ-004 Port Sum, output, 1: combinational sum bit, A ^ B ^ Cin.
REQ-005 Port Cout, output, 1: combinational carry-out, majority(A, B, Cin).
REQ-006 Port A, input, 1: addend bit.
REQ-007 Port B, input, 1: addend bit.
REQ-008 Port Cin, input, 1: carry-in bit.
REQ-009 Port in_valid, input, 1: qualifies A/B/Cin for the registered path and statistics.
REQ-010 Port sum_q, output, 1: registered Sum.
REQ-011 Port cout_q, output, 1: registered Cout.
REQ-012 Port out_valid, output, 1: registered in_valid; marks sum_q/cout_q as fresh.
REQ-013 Port carry_cnt, output, CNT_W: count of accepted operations with Cout=1.
REQ-014 Port order SHALL be clk, rst, Sum, Cout, A, B, Cin, in_valid, sum_q, cout_q, out_valid, carry_cnt.

Function
REQ-015 Sum and Cout SHALL be purely combinational, zero latency, and independent of clk, rst and in_valid.
REQ-016 Truth table for A,B,Cin -> Sum,Cout: 000->00, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11.
REQ-017 On a clk edge with in_valid=1 and rst=0, sum_q/cout_q SHALL load the current Sum/Cout, giving 1-cycle latency.
REQ-018 On a clk edge with in_valid=0 and rst=0, sum_q/cout_q SHALL hold their previous values.
REQ-019 On every clk edge with rst=0, out_valid SHALL load in_valid.
REQ-020 On a clk edge with in_valid=1, Cout=1 and rst=0, carry_cnt SHALL increment by 1.
REQ-021 carry_cnt SHALL saturate at 2^CNT_W-1 and never wrap to 0.
REQ-022 Back-to-back in_valid cycles SHALL each be accepted, giving one result per cycle with no stalls.
REQ-023 X or Z on an input SHALL NOT affect registered state while in_valid=0.

Reset
REQ-024 When rst=1 at a clk edge, sum_q, cout_q and out_valid SHALL become 0 and carry_cnt SHALL become 0.
REQ-025 Reset SHALL take priority over in_valid on the same edge; the operation presented on that edge is discarded.
REQ-026 Sum and Cout SHALL continue to follow A/B/Cin while rst=1.
REQ-027 Deasserting rst mid-stream SHALL allow acceptance on the first edge where rst=0.

Configuration
REQ-028 Macro FULL_ADDER_V2_STATS_EN defined: carry_cnt SHALL be implemented as described in REQ-020, REQ-021 and REQ-024.
REQ-029 Macro FULL_ADDER_V2_STATS_EN undefined: the counter logic SHALL be omitted, carry_cnt SHALL be constant 0, and all other behaviour SHALL be unchanged.

Verification
REQ-030 Exhaustive check: apply all 8 A/B/Cin combinations, 20 time units apart -> Sum/Cout match REQ-016 within the same time step.
REQ-031 Registered path: set in_valid=1 with A=1, B=1, Cin=0 -> one edge later, sum_q=0, cout_q=1 and out_valid=1.
REQ-032 Hold: after REQ-031, set in_valid=0 with A=0, B=0, Cin=1 -> sum_q=0 and cout_q=1 persist, out_valid=0.
REQ-033 Counter: with STATS_EN defined, apply 300 valid cycles of 1,1,1 with CNT_W=8 -> carry_cnt=255, then no wrap.
REQ-034 Reset priority: assert rst=1 together with in_valid=1 and inputs 1,1,1 -> all registered outputs=0 on the next edge, while Sum=1 and Cout=1.
REQ-035 Macro off: run REQ-033 with STATS_EN undefined -> carry_cnt=0 throughout.
